// File: rtl/macc_scheduler.sv
// Frame-granular round-robin scheduler that time-shares one MAC between NCH
// A/B sample streams and tags each accumulator result with its channel id.
module macc_scheduler #(
    parameter int NCH       = 4,
    parameter int ADW       = 24,
    parameter int BDW       = 18,
    parameter int ODW       = 48,
    parameter int IDQ_DEPTH = 4,
    localparam int IDW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*ADW-1:0]   s_axis_atdata,
    input  logic [NCH-1:0]       s_axis_atvalid,
    output logic [NCH-1:0]       s_axis_atready,
    input  logic [NCH-1:0]       s_axis_atlast,
    input  logic [NCH*BDW-1:0]   s_axis_btdata,
    input  logic [NCH-1:0]       s_axis_btvalid,
    output logic [NCH-1:0]       s_axis_btready,
    output logic [ADW-1:0]       m_macc_atdata,
    output logic                 m_macc_atvalid,
    input  logic                 m_macc_atready,
    output logic                 m_macc_atlast,
    output logic [BDW-1:0]       m_macc_btdata,
    output logic                 m_macc_btvalid,
    input  logic                 m_macc_btready,
    input  logic [ODW-1:0]       s_macc_tdata,
    input  logic                 s_macc_tvalid,
    output logic                 s_macc_tready,
    output logic [ODW-1:0]       m_axis_tdata,
    output logic [IDW-1:0]       m_axis_tid,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 err_orphan
);

    localparam int QAW = $clog2(IDQ_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]             r_state;
    logic [IDW-1:0]         r_grant;
    logic [IDW-1:0]         r_rr;
    logic                   r_err;

    logic [NCH-1:0]         w_req;
    logic                   w_any;
    logic [IDW-1:0]         w_sel;
    logic [IDW-1:0]         w_cand;

    logic signed [ADW-1:0]  r_a_p0;
    logic signed [BDW-1:0]  r_b_p0;
    logic                   r_last_p0;
    logic                   r_vld_a_p0;
    logic                   r_vld_b_p0;

    logic [IDW-1:0]         r_idq [IDQ_DEPTH];
    logic [QAW:0]           r_wptr;
    logic [QAW:0]           r_rptr;

    logic signed [ADW-1:0]  w_g_a;
    logic signed [BDW-1:0]  w_g_b;
    logic                   w_g_av;
    logic                   w_g_bv;
    logic                   w_g_last;
    logic                   w_a_hs;
    logic                   w_b_hs;
    logic                   w_pair_free;
    logic                   w_rdy;
    logic                   w_load;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_q_empty;
    logic                   w_q_full;

    assign w_req = s_axis_atvalid & s_axis_btvalid;

    // Round-robin search starting one past the last channel that finished a frame.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = r_rr;
        for (int k = 0; k < NCH; k++) begin
            w_cand = (w_cand == IDW'(NCH - 1)) ? '0 : w_cand + 1'b1;
            if (!w_any && w_req[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
    end

    assign w_g_a    = s_axis_atdata[int'(r_grant)*ADW +: ADW];
    assign w_g_b    = s_axis_btdata[int'(r_grant)*BDW +: BDW];
    assign w_g_av   = s_axis_atvalid[r_grant];
    assign w_g_bv   = s_axis_btvalid[r_grant];
    assign w_g_last = s_axis_atlast[r_grant];

    assign w_q_empty = (r_wptr == r_rptr);
    assign w_q_full  = (r_wptr[QAW] != r_rptr[QAW]) &&
                       (r_wptr[QAW-1:0] == r_rptr[QAW-1:0]);

    // A and B drain independently; the pair reloads only once both sides are gone.
    assign w_a_hs      = r_vld_a_p0 && m_macc_atready;
    assign w_b_hs      = r_vld_b_p0 && m_macc_btready;
    assign w_pair_free = (!r_vld_a_p0 || w_a_hs) && (!r_vld_b_p0 || w_b_hs);
    assign w_rdy       = (r_state == S_BUSY) && w_pair_free && (!w_g_last || !w_q_full);
    assign w_load      = w_rdy && w_g_av && w_g_bv;
    assign w_push      = w_load && w_g_last;
    assign w_pop       = s_macc_tvalid && m_axis_tready && !w_q_empty;

    always_comb begin
        s_axis_atready = '0;
        if (w_rdy) begin
            s_axis_atready[r_grant] = 1'b1;
        end
    end
    assign s_axis_btready = s_axis_atready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_rr    <= IDW'(NCH - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    if (w_push) begin
                        r_rr    <= r_grant;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Stage p0: pair register feeding the MAC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_a_p0 <= 1'b0;
            r_vld_b_p0 <= 1'b0;
        end else begin
            if (w_load) begin
                r_vld_a_p0 <= 1'b1;
                r_vld_b_p0 <= 1'b1;
            end else begin
                if (w_a_hs) r_vld_a_p0 <= 1'b0;
                if (w_b_hs) r_vld_b_p0 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_a_p0    <= w_g_a;
            r_b_p0    <= w_g_b;
            r_last_p0 <= w_g_last;
        end
    end

    assign m_macc_atdata  = r_a_p0;
    assign m_macc_btdata  = r_b_p0;
    assign m_macc_atlast  = r_last_p0;
    assign m_macc_atvalid = r_vld_a_p0;
    assign m_macc_btvalid = r_vld_b_p0;

    // Id queue: one entry per frame handed to the MAC, retired per tagged result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (s_macc_tvalid && w_q_empty) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idq[r_wptr[QAW-1:0]] <= r_grant;
        end
    end

    assign m_axis_tdata  = s_macc_tdata;
    assign m_axis_tid    = r_idq[r_rptr[QAW-1:0]];
    assign m_axis_tvalid = s_macc_tvalid && !w_q_empty;
    assign s_macc_tready = m_axis_tready && !w_q_empty;
    assign err_orphan    = r_err;

endmodule

// File: tb/tb_macc_scheduler.sv
// Scoreboard bench for macc_scheduler: per-channel source queues, a MAC-side
// monitor checking issued beats in order, and an output monitor checking tags.
module tb_macc_scheduler;

    localparam int NCH       = 4;
    localparam int ADW       = 24;
    localparam int BDW       = 18;
    localparam int ODW       = 48;
    localparam int IDQ_DEPTH = 4;
    localparam int IDW       = 2;

    logic               clk;
    logic               rst;
    logic [NCH*ADW-1:0] s_axis_atdata;
    logic [NCH-1:0]     s_axis_atvalid;
    logic [NCH-1:0]     s_axis_atready;
    logic [NCH-1:0]     s_axis_atlast;
    logic [NCH*BDW-1:0] s_axis_btdata;
    logic [NCH-1:0]     s_axis_btvalid;
    logic [NCH-1:0]     s_axis_btready;
    logic [ADW-1:0]     m_macc_atdata;
    logic               m_macc_atvalid;
    logic               m_macc_atready;
    logic               m_macc_atlast;
    logic [BDW-1:0]     m_macc_btdata;
    logic               m_macc_btvalid;
    logic               m_macc_btready;
    logic [ODW-1:0]     s_macc_tdata;
    logic               s_macc_tvalid;
    logic               s_macc_tready;
    logic [ODW-1:0]     m_axis_tdata;
    logic [IDW-1:0]     m_axis_tid;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               err_orphan;

    macc_scheduler #(
        .NCH(NCH), .ADW(ADW), .BDW(BDW), .ODW(ODW), .IDQ_DEPTH(IDQ_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_atdata(s_axis_atdata), .s_axis_atvalid(s_axis_atvalid),
        .s_axis_atready(s_axis_atready), .s_axis_atlast(s_axis_atlast),
        .s_axis_btdata(s_axis_btdata), .s_axis_btvalid(s_axis_btvalid),
        .s_axis_btready(s_axis_btready),
        .m_macc_atdata(m_macc_atdata), .m_macc_atvalid(m_macc_atvalid),
        .m_macc_atready(m_macc_atready), .m_macc_atlast(m_macc_atlast),
        .m_macc_btdata(m_macc_btdata), .m_macc_btvalid(m_macc_btvalid),
        .m_macc_btready(m_macc_btready),
        .s_macc_tdata(s_macc_tdata), .s_macc_tvalid(s_macc_tvalid),
        .s_macc_tready(s_macc_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .err_orphan(err_orphan)
    );

    typedef struct packed {
        logic [ADW-1:0] a;
        logic [BDW-1:0] b;
        logic           last;
    } beat_t;

    typedef struct packed {
        logic [ODW-1:0] d;
        logic [IDW-1:0] id;
    } res_t;

    beat_t          src_q [NCH][$];
    beat_t          exp_a [$];
    beat_t          exp_b [$];
    res_t           exp_out [$];
    logic [ODW-1:0] mac_res [$];

    logic a_rdy_c;
    logic b_rdy_c;
    logic out_rdy_c;

    int n_chk;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic at_mid();
        @(negedge clk);
        #2;
    endtask

    task automatic src_beat(input int ch, input int a, input int b, input bit last);
        beat_t x;
        x.a = ADW'(a);
        x.b = BDW'(b);
        x.last = last;
        src_q[ch].push_back(x);
    endtask

    task automatic exp_beat(input int a, input int b, input bit last);
        beat_t x;
        x.a = ADW'(a);
        x.b = BDW'(b);
        x.last = last;
        exp_a.push_back(x);
        exp_b.push_back(x);
    endtask

    task automatic beat(input int ch, input int a, input int b, input bit last);
        src_beat(ch, a, b, last);
        exp_beat(a, b, last);
    endtask

    task automatic exp_res(input longint d, input int id);
        res_t r;
        r.d = ODW'(d);
        r.id = IDW'(id);
        exp_out.push_back(r);
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (src_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_mac_drain(input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 300) begin
            at_mid();
            n++;
            done = srcs_empty() && exp_a.size() == 0 && exp_b.size() == 0;
        end
        chk({name, "_mac_drain"}, 64'(done), 64'd1);
    endtask

    task automatic wait_out_drain(input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 300) begin
            at_mid();
            n++;
            done = exp_out.size() == 0 && mac_res.size() == 0;
        end
        chk({name, "_out_drain"}, 64'(done), 64'd1);
    endtask

    task automatic wait_atvalid(input string name);
        int n = 0;
        while (!m_macc_atvalid && n < 50) begin
            at_mid();
            n++;
        end
        chk({name, "_atvalid_seen"}, 64'(m_macc_atvalid), 64'd1);
    endtask

    // Source driver, MAC model and both monitors share one cycle loop:
    // drive just after negedge, sample just before posedge.
    initial begin
        beat_t h;
        beat_t e;
        res_t  r;
        s_axis_atdata  = '0;
        s_axis_btdata  = '0;
        s_axis_atvalid = '0;
        s_axis_btvalid = '0;
        s_axis_atlast  = '0;
        s_macc_tvalid  = 1'b0;
        s_macc_tdata   = '0;
        m_macc_atready = 1'b0;
        m_macc_btready = 1'b0;
        m_axis_tready  = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    s_axis_atvalid[i] = 1'b1;
                    s_axis_btvalid[i] = 1'b1;
                    s_axis_atlast[i]  = h.last;
                    s_axis_atdata[i*ADW +: ADW] = h.a;
                    s_axis_btdata[i*BDW +: BDW] = h.b;
                end else begin
                    s_axis_atvalid[i] = 1'b0;
                    s_axis_btvalid[i] = 1'b0;
                    s_axis_atlast[i]  = 1'b0;
                end
            end
            s_macc_tvalid  = (mac_res.size() > 0);
            s_macc_tdata   = (mac_res.size() > 0) ? mac_res[0] : '0;
            m_macc_atready = a_rdy_c;
            m_macc_btready = b_rdy_c;
            m_axis_tready  = out_rdy_c;
            #4;
            if (!rst) begin
                chk("btready_eq_atready", 64'(s_axis_btready), 64'(s_axis_atready));
                for (int i = 0; i < NCH; i++) begin
                    if (s_axis_atvalid[i] && s_axis_btvalid[i] && s_axis_atready[i])
                        void'(src_q[i].pop_front());
                end
                if (m_macc_atvalid && m_macc_atready) begin
                    if (exp_a.size() == 0) chk("mac_a_unexpected", 64'd1, 64'd0);
                    else begin
                        e = exp_a.pop_front();
                        chk("mac_a", {39'd0, m_macc_atlast, m_macc_atdata}, {39'd0, e.last, e.a});
                    end
                end
                if (m_macc_btvalid && m_macc_btready) begin
                    if (exp_b.size() == 0) chk("mac_b_unexpected", 64'd1, 64'd0);
                    else begin
                        e = exp_b.pop_front();
                        chk("mac_b", 64'(m_macc_btdata), 64'(e.b));
                    end
                end
                if (s_macc_tvalid && s_macc_tready) void'(mac_res.pop_front());
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_out.size() == 0) chk("m_axis_unexpected", 64'd1, 64'd0);
                    else begin
                        r = exp_out.pop_front();
                        chk("m_axis_tid", 64'(m_axis_tid), 64'(r.id));
                        chk("m_axis_tdata", 64'(m_axis_tdata), 64'(r.d));
                    end
                end
            end
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        a_rdy_c = 1'b1;
        b_rdy_c = 1'b1;
        out_rdy_c = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // reset state
        at_mid();
        chk("rst_atready", 64'(s_axis_atready), 64'd0);
        chk("rst_macc_avalid", 64'(m_macc_atvalid), 64'd0);
        chk("rst_macc_bvalid", 64'(m_macc_btvalid), 64'd0);
        chk("rst_m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_s_macc_tready", 64'(s_macc_tready), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        rst = 1'b0;

        // ch1 alone, 3-beat frame, check grant-to-issue latency
        at_mid();
        beat(1, 1, 4, 0);
        beat(1, 2, 5, 0);
        beat(1, 3, 6, 1);
        exp_res(32, 1);
        at_mid();
        chk("t1_idle_no_ready", 64'(s_axis_atready), 64'd0);
        at_mid();
        chk("t1_busy_ready_ch1", 64'(s_axis_atready), 64'b0010);
        chk("t1_no_valid_yet", 64'(m_macc_atvalid), 64'd0);
        at_mid();
        chk("t1_valid_n2", 64'(m_macc_atvalid), 64'd1);
        wait_mac_drain("t1");
        mac_res.push_back(48'd32);
        wait_out_drain("t1");

        // ch0 and ch2 contend; rr was left at 1 so ch2 goes first
        src_beat(0, 10, 110, 0); src_beat(0, 11, 111, 1);
        src_beat(0, 12, 112, 0); src_beat(0, 13, 113, 1);
        src_beat(2, 20, 120, 0); src_beat(2, 21, 121, 1);
        src_beat(2, 22, 122, 0); src_beat(2, 23, 123, 1);
        exp_beat(20, 120, 0); exp_beat(21, 121, 1);
        exp_beat(10, 110, 0); exp_beat(11, 111, 1);
        exp_beat(22, 122, 0); exp_beat(23, 123, 1);
        exp_beat(12, 112, 0); exp_beat(13, 113, 1);
        exp_res(100, 2); exp_res(200, 0); exp_res(300, 2); exp_res(400, 0);
        wait_mac_drain("t2");
        mac_res.push_back(48'd100); mac_res.push_back(48'd200);
        mac_res.push_back(48'd300); mac_res.push_back(48'd400);
        wait_out_drain("t2");

        // MAC holds A off while taking B; signed B values
        a_rdy_c = 1'b0;
        beat(1, 7, -4, 0);
        beat(1, 8, -5, 0);
        beat(1, 9, -6, 1);
        exp_res(77, 1);
        wait_atvalid("t3");
        at_mid();
        chk("t3_a_held_valid", 64'(m_macc_atvalid), 64'd1);
        chk("t3_a_held_data", 64'(m_macc_atdata), 64'd7);
        chk("t3_b_taken", 64'(m_macc_btvalid), 64'd0);
        chk("t3_no_new_pair", 64'(s_axis_atready), 64'd0);
        at_mid();
        chk("t3_a_still_data", 64'(m_macc_atdata), 64'd7);
        a_rdy_c = 1'b1;
        wait_mac_drain("t3");
        mac_res.push_back(48'd77);
        wait_out_drain("t3");

        // id queue fills with four single-beat frames; the fifth last beat stalls
        out_rdy_c = 1'b0;
        for (int k = 0; k < 5; k++) begin
            beat(0, 30 + k, k + 1, 1);
            exp_res(500 + k, 0);
        end
        begin
            int n = 0;
            while (exp_a.size() != 1 && n < 100) begin
                at_mid();
                n++;
            end
            chk("t4_four_issued", 64'(exp_a.size()), 64'd1);
        end
        at_mid();
        at_mid();
        chk("t4_full_stall_ready", 64'(s_axis_atready), 64'd0);
        chk("t4_full_stall_valid", 64'(m_macc_atvalid), 64'd0);
        mac_res.push_back(48'd500);
        out_rdy_c = 1'b1;
        at_mid();
        chk("t4_pop_cycle_ready", 64'(s_axis_atready), 64'd0);
        at_mid();
        chk("t4_after_pop_ready", 64'(s_axis_atready), 64'b0001);
        wait_mac_drain("t4");
        for (int k = 1; k < 5; k++) mac_res.push_back(ODW'(500 + k));
        wait_out_drain("t4");

        // orphan result: held until a later frame supplies the id
        mac_res.push_back(48'h123);
        exp_res(48'h123, 2);
        at_mid();
        chk("t5_orphan_tvalid", 64'(m_axis_tvalid), 64'd0);
        at_mid();
        chk("t5_err_orphan_set", 64'(err_orphan), 64'd1);
        chk("t5_orphan_tvalid2", 64'(m_axis_tvalid), 64'd0);
        chk("t5_orphan_tready", 64'(s_macc_tready), 64'd0);
        beat(2, 5, 6, 1);
        wait_mac_drain("t5");
        wait_out_drain("t5");
        chk("t5_err_sticky", 64'(err_orphan), 64'd1);

        // reset mid-frame on ch3; ch0 must win next even though rr was at 2
        beat(3, 40, 1, 0);
        beat(3, 41, 2, 0);
        beat(3, 42, 3, 0);
        beat(3, 43, 4, 1);
        wait_atvalid("t6");
        rst = 1'b1;
        src_q[3].delete();
        exp_a.delete();
        exp_b.delete();
        at_mid();
        chk("t6_rst_atready", 64'(s_axis_atready), 64'd0);
        chk("t6_rst_avalid", 64'(m_macc_atvalid), 64'd0);
        chk("t6_rst_bvalid", 64'(m_macc_btvalid), 64'd0);
        chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_rst_err", 64'(err_orphan), 64'd0);
        rst = 1'b0;
        src_beat(0, 50, 7, 1);
        src_beat(3, 60, 8, 1);
        exp_beat(50, 7, 1);
        exp_beat(60, 8, 1);
        exp_res(900, 0);
        exp_res(901, 3);
        wait_mac_drain("t6");
        mac_res.push_back(48'd900);
        mac_res.push_back(48'd901);
        wait_out_drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
